// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB-Lite encodings and responder FSM states shared by the memory slave
package ahb_pkg;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;
    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;
endpackage

// File: rtl/ahb_mem_array.sv
// ahb_mem_array: word array with byte-lane write enables and asynchronous read
module ahb_mem_array #(
    parameter int DEPTH = 256,
    localparam int IW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [IW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [DEPTH];
    always_ff @(posedge clk)
        for (int i = 0; i < 4; i++)
            if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    assign rdata = mem[addr];
endmodule

// File: rtl/ahb_mem_slave.sv
// ahb_mem_slave: AHB-Lite responder with programmable wait states and two-cycle ERROR
module ahb_mem_slave
    import ahb_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int HBURST_WIDTH = 3,
    parameter int MEM_DEPTH    = 256,
    parameter int WAIT_STATES  = 0
) (
    input  logic                    HCLK,
    input  logic                    HRST,
    input  logic                    HSEL,
    input  logic [ADDR_WIDTH-1:0]   HADDR,
    input  logic                    HWRITE,
    input  logic [2:0]              HSIZE,
    input  logic [HBURST_WIDTH-1:0] HBURST,
    input  logic [3:0]              HPROT,
    input  logic [1:0]              HTRANS,
    input  logic                    HMASTERLOCK,
    input  logic                    HREADY,
    input  logic [DATA_WIDTH-1:0]   HWDATA,
    output logic                    HREADYOUT,
    output logic                    HRESP,
    output logic [DATA_WIDTH-1:0]   HRDATA
);
    localparam int IW = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(4 * MEM_DEPTH);
    localparam logic [3:0] CNT_LOAD = WAIT_STATES > 0 ? 4'(WAIT_STATES - 1) : 4'd0;
    state_t state, state_n;
    logic [IW+1:0] addr_q;
    logic [2:0] size_q;
    logic write_q, accept, err, we, unused_ok;
    logic [3:0] cnt, be;
    logic [31:0] rdata;
    assign accept = HSEL & HREADY & HTRANS[1];
    assign err = HADDR >= ADDR_LIMIT || HSIZE > HSIZE_WORD ||
                 (HSIZE == HSIZE_HALF && HADDR[0]) ||
                 (HSIZE == HSIZE_WORD && HADDR[1:0] != 2'b00);
    always_comb begin
        state_n = state == S_WAIT ? (cnt == 4'd0 ? S_DATA : S_WAIT) :
                  state == S_ERR1 ? S_ERR2 :
                  !accept         ? S_IDLE :
                  err             ? S_ERR1 :
                  WAIT_STATES > 0 ? S_WAIT : S_DATA;
    end
    // Outputs are registered from the next state so they are glitch-free on the bus.
    always_ff @(posedge HCLK) begin
        if (HRST) begin
            state     <= S_IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= HRESP_OKAY;
            cnt       <= 4'd0;
            addr_q    <= '0;
            size_q    <= '0;
            write_q   <= 1'b0;
        end else begin
            state     <= state_n;
            HREADYOUT <= !(state_n == S_WAIT || state_n == S_ERR1);
            HRESP     <= (state_n == S_ERR1 || state_n == S_ERR2) ? HRESP_ERROR : HRESP_OKAY;
            cnt       <= state == S_WAIT ? cnt - 4'd1 : CNT_LOAD;
            if (accept) begin
                addr_q  <= HADDR[IW+1:0];
                size_q  <= HSIZE;
                write_q <= HWRITE;
            end
        end
    end
    assign we = state == S_DATA && write_q;
    assign be = size_q == HSIZE_WORD ? 4'hF :
                size_q == HSIZE_HALF ? (addr_q[1] ? 4'hC : 4'h3) :
                4'b0001 << addr_q[1:0];
    ahb_mem_array #(.DEPTH(MEM_DEPTH)) u_mem (
        .clk   (HCLK),
        .we    (we),
        .be    (be),
        .addr  (addr_q[IW+1:2]),
        .wdata (HWDATA[31:0]),
        .rdata (rdata)
    );
    assign HRDATA = state == S_DATA ? DATA_WIDTH'(rdata) : '0;
    assign unused_ok = &{1'b0, HBURST, HPROT, HMASTERLOCK, HTRANS[0]};
endmodule

// File: tb/tb_ahb_mem_slave.sv
// tb_ahb_mem_slave: two responders (0 and 2 wait states) on one bus, checked against a scoreboard
module tb_ahb_mem_slave;
    import ahb_pkg::*;

    typedef struct {
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } beat_t;

    typedef struct {
        string       tag;
        logic        resp;
        logic        chk;
        logic [31:0] data;
        int          waits;
    } exp_t;

    logic HCLK = 1'b0;
    logic HRST, hsel, sel, HWRITE, HMASTERLOCK;
    logic [31:0] HADDR, HWDATA;
    logic [2:0] HSIZE, HBURST;
    logic [3:0] HPROT;
    logic [1:0] HTRANS;
    logic ro0, ro1, rs0, rs1, HREADY, HRESP;
    logic [31:0] rd0, rd1, HRDATA;

    beat_t prog[$];
    exp_t sbq[$];
    logic [31:0] ref_mem [2][256];
    int vectors = 0;
    int miscompares = 0;

    always #5 HCLK = ~HCLK;

    assign HREADY = sel ? ro1 : ro0;
    assign HRESP  = sel ? rs1 : rs0;
    assign HRDATA = sel ? rd1 : rd0;

    ahb_mem_slave #(.WAIT_STATES(0)) dut0 (
        .HCLK(HCLK), .HRST(HRST), .HSEL(hsel & ~sel), .HADDR(HADDR), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
        .HMASTERLOCK(HMASTERLOCK), .HREADY(HREADY), .HWDATA(HWDATA),
        .HREADYOUT(ro0), .HRESP(rs0), .HRDATA(rd0)
    );

    ahb_mem_slave #(.WAIT_STATES(2)) dut1 (
        .HCLK(HCLK), .HRST(HRST), .HSEL(hsel & sel), .HADDR(HADDR), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
        .HMASTERLOCK(HMASTERLOCK), .HREADY(HREADY), .HWDATA(HWDATA),
        .HREADYOUT(ro1), .HRESP(rs1), .HRDATA(rd1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic beat_t bt(input logic [1:0] t, input logic w, input logic [2:0] z,
                                 input logic [31:0] a, input logic [31:0] d);
        beat_t b;
        b.trans = t; b.wr = w; b.size = z; b.addr = a; b.wdata = d;
        return b;
    endfunction

    function automatic logic bad(input beat_t b);
        return b.addr >= 32'd1024 || b.size > 3'd2 ||
               (b.size == 3'd1 && b.addr[0]) || (b.size == 3'd2 && b.addr[1:0] != 2'b00);
    endfunction

    // Builds the expected response and applies writes to the reference memory.
    function automatic exp_t expect_beat(input beat_t b, input logic s, input string tag);
        exp_t e;
        int idx;
        logic hit;
        e.tag = tag; e.resp = 1'b0; e.chk = 1'b0; e.data = '0; e.waits = 0;
        if (b.trans[1]) begin
            if (bad(b)) begin
                e.resp = 1'b1;
                e.waits = 1;
            end else begin
                e.waits = s ? 2 : 0;
                idx = int'(b.addr[9:2]);
                if (b.wr) begin
                    for (int k = 0; k < 4; k++) begin
                        hit = b.size == 3'd0 ? (k == int'(b.addr[1:0])) :
                              b.size == 3'd1 ? ((k / 2) == int'(b.addr[1])) : 1'b1;
                        if (hit) ref_mem[int'(s)][idx][8*k +: 8] = b.wdata[8*k +: 8];
                    end
                end else begin
                    e.chk = 1'b1;
                    e.data = ref_mem[int'(s)][idx];
                end
            end
        end
        return e;
    endfunction

    // Pipelined master: drives prog[] on slave s, pushes expectations at accept, pops at completion.
    task automatic run(input string name, input logic s);
        int i = 0;
        int guard = 0;
        int stalls = 0;
        logic dp = 1'b0;
        logic hr;
        exp_t e;
        sel = s;
        while (i < prog.size() || dp) begin
            if (i < prog.size()) begin
                hsel = 1'b1; HTRANS = prog[i].trans; HWRITE = prog[i].wr;
                HSIZE = prog[i].size; HADDR = prog[i].addr;
            end else begin
                hsel = 1'b0; HTRANS = HTRANS_IDLE;
            end
            @(negedge HCLK);
            if (dp && HREADY) begin
                e = sbq.pop_front();
                check({e.tag, " resp"}, 32'(HRESP), 32'(e.resp));
                check({e.tag, " waits"}, 32'(stalls), 32'(e.waits));
                if (e.chk) check({e.tag, " rdata"}, HRDATA, e.data);
                dp = 1'b0;
            end else if (dp) begin
                stalls++;
                check({sbq[0].tag, " stall resp"}, 32'(HRESP), 32'(sbq[0].resp));
            end
            hr = HREADY;
            @(posedge HCLK); #1;
            if (hr && i < prog.size()) begin
                sbq.push_back(expect_beat(prog[i], s, $sformatf("%s[%0d]", name, i)));
                HWDATA = prog[i].wdata;
                dp = 1'b1;
                stalls = 0;
                i++;
            end
            if (++guard > 100) begin
                check({name, " timeout"}, 32'd1, 32'd0);
                break;
            end
        end
        sbq.delete();
        prog.delete();
    endtask

    initial begin
        foreach (ref_mem[a, b]) ref_mem[a][b] = '0;
        sel = 1'b0; hsel = 1'b0; HTRANS = HTRANS_IDLE; HADDR = '0; HWRITE = 1'b0;
        HSIZE = HSIZE_WORD; HWDATA = '0; HBURST = 3'b011; HPROT = 4'b0011;
        HMASTERLOCK = 1'b0; HRST = 1'b1;
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        check("reset hreadyout0", 32'(ro0), 32'd1);
        check("reset hresp0", 32'(rs0), 32'd0);
        check("reset hrdata0", rd0, 32'd0);
        check("reset hreadyout1", 32'(ro1), 32'd1);
        check("reset hresp1", 32'(rs1), 32'd0);
        check("reset hrdata1", rd1, 32'd0);
        @(posedge HCLK); #1;
        HRST = 1'b0;

        prog.push_back(bt(HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h10, 32'hDEADBEEF));
        prog.push_back(bt(HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h10, 32'h0));
        prog.push_back(bt(HTRANS_IDLE,   0, HSIZE_WORD, 32'h0,  32'h0));
        run("word_wr_rd", 1'b0);

        prog.push_back(bt(HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h20, 32'h00000000));
        prog.push_back(bt(HTRANS_NONSEQ, 1, HSIZE_BYTE, 32'h22, 32'h00AB0000));
        prog.push_back(bt(HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h20, 32'h0));
        prog.push_back(bt(HTRANS_NONSEQ, 1, HSIZE_BYTE, 32'h21, 32'h00005A00));
        prog.push_back(bt(HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h24, 32'h11111111));
        prog.push_back(bt(HTRANS_NONSEQ, 1, HSIZE_HALF, 32'h26, 32'hCAFE0000));
        prog.push_back(bt(HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h20, 32'h0));
        prog.push_back(bt(HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h24, 32'h0));
        prog.push_back(bt(HTRANS_IDLE,   0, HSIZE_WORD, 32'h0,  32'h0));
        run("lanes", 1'b0);

        prog.push_back(bt(HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h80, 32'hA5A5F00F));
        prog.push_back(bt(HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h80, 32'h0));
        prog.push_back(bt(HTRANS_IDLE,   0, HSIZE_WORD, 32'h0,  32'h0));
        run("wait2", 1'b1);

        prog.push_back(bt(HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h3FC, 32'h0BADF00D));
        prog.push_back(bt(HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h3FC, 32'h0));
        prog.push_back(bt(HTRANS_NONSEQ, 0, HSIZE_BYTE, 32'h3FF, 32'h0));
        prog.push_back(bt(HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h400, 32'h0));
        prog.push_back(bt(HTRANS_IDLE,   0, HSIZE_WORD, 32'h0,   32'h0));
        prog.push_back(bt(HTRANS_NONSEQ, 0, 3'b011,     32'h0,   32'h0));
        prog.push_back(bt(HTRANS_IDLE,   0, HSIZE_WORD, 32'h0,   32'h0));
        run("range", 1'b0);

        prog.push_back(bt(HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h40, 32'h01010101));
        prog.push_back(bt(HTRANS_SEQ,    1, HSIZE_WORD, 32'h44, 32'h02020202));
        prog.push_back(bt(HTRANS_BUSY,   1, HSIZE_WORD, 32'h48, 32'hFFFFFFFF));
        prog.push_back(bt(HTRANS_SEQ,    1, HSIZE_WORD, 32'h48, 32'h03030303));
        prog.push_back(bt(HTRANS_SEQ,    1, HSIZE_WORD, 32'h4C, 32'h04040404));
        prog.push_back(bt(HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h40, 32'h0));
        prog.push_back(bt(HTRANS_SEQ,    0, HSIZE_WORD, 32'h44, 32'h0));
        prog.push_back(bt(HTRANS_SEQ,    0, HSIZE_WORD, 32'h48, 32'h0));
        prog.push_back(bt(HTRANS_SEQ,    0, HSIZE_WORD, 32'h4C, 32'h0));
        prog.push_back(bt(HTRANS_IDLE,   0, HSIZE_WORD, 32'h0,  32'h0));
        run("incr4", 1'b0);

        prog.push_back(bt(HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h00, 32'h11223344));
        prog.push_back(bt(HTRANS_NONSEQ, 1, HSIZE_HALF, 32'h01, 32'hFFFFFFFF));
        prog.push_back(bt(HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h06, 32'hFFFFFFFF));
        prog.push_back(bt(HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h00, 32'h0));
        prog.push_back(bt(HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h04, 32'h0));
        prog.push_back(bt(HTRANS_IDLE,   0, HSIZE_WORD, 32'h0,  32'h0));
        run("misalign", 1'b0);

        sel = 1'b1; hsel = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b1;
        HSIZE = HSIZE_WORD; HADDR = 32'h80;
        @(posedge HCLK); #1;
        hsel = 1'b0; HTRANS = HTRANS_IDLE; HWDATA = 32'h12345678;
        @(negedge HCLK);
        check("rst_wait hreadyout", 32'(ro1), 32'd0);
        HRST = 1'b1;
        @(posedge HCLK); #1;
        HRST = 1'b0;
        @(negedge HCLK);
        check("rst_wait post hreadyout", 32'(ro1), 32'd1);
        check("rst_wait post hresp", 32'(rs1), 32'd0);
        @(posedge HCLK); #1;
        prog.push_back(bt(HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h80, 32'h0));
        prog.push_back(bt(HTRANS_IDLE,   0, HSIZE_WORD, 32'h0,  32'h0));
        run("rst_nowrite", 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
